// File: rtl/uram_find_sched.sv
// Round-robin scheduler that shares one uram_ctrl find engine among NUM_REQ requesters.
// It grants one command at a time, supervises the engine busy handshake and routes the result back to the owner.
//
// state       | meaning
// S_IDLE      | arbitrate among pending requests, grant one
// S_ISSUE     | latched command on uram_data_in, counter cleared
// S_WAIT_BUSY | wait for uram_busy to rise (START_TO cycles)
// S_WAIT_DONE | wait for uram_busy to fall (DONE_TO cycles)
// S_RESP      | one-cycle response pulse to the owner
// S_GAP       | NOP_CMD for GAP_CYC cycles before the next grant
module uram_find_sched #(
    parameter int          NUM_REQ  = 4,
    parameter int          START_TO = 16,
    parameter int          DONE_TO  = 4096,
    parameter int          GAP_CYC  = 2,
    parameter logic [31:0] NOP_CMD  = 32'h0
) (
    input  logic                   clk_main_a0,
    input  logic                   rst_main_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  req_cmd,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_ok,
    output logic                   rsp_ko,
    output logic                   rsp_timeout,
    output logic [31:0]            uram_data_in,
    input  logic                   uram_busy,
    input  logic                   uram_find_ok,
    input  logic                   uram_find_ko,
    output logic                   sched_busy,
    output logic [15:0]            timeout_cnt
);

    localparam int MAX_TO = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int CNT_W  = $clog2(MAX_TO);
    localparam int PTR_W  = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [CNT_W-1:0]     r_cnt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_rsp_ok;
    logic                 r_rsp_ko;
    logic                 r_rsp_timeout;
    logic [31:0]          r_data_in;
    logic [15:0]          r_timeout_cnt;

    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [31:0]          w_cmd;
    logic                 w_grant;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic                 w_resp_load;
    logic                 w_resp_ok;
    logic                 w_resp_ko;
    logic                 w_resp_to;

    // Assertion is asynchronous; release is resynchronised to clk_main_a0.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            automatic int          k   = (int'(r_rr_ptr) + i) % NUM_REQ;
            automatic logic [PTR_W-1:0] idx = PTR_W'(k);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_cmd = req_cmd[{w_win, 5'b00000} +: 32];

    always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_resp_load = 1'b0;
        w_resp_ok   = 1'b0;
        w_resp_ko   = 1'b0;
        w_resp_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uram_busy) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == CNT_W'(START_TO - 1)) begin
                    w_resp_load = 1'b1;
                    w_resp_to   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!uram_busy) begin
                    w_resp_load = 1'b1;
                    w_resp_ok   = uram_find_ok;
                    w_resp_ko   = uram_find_ko;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CNT_W'(DONE_TO - 1)) begin
                    w_resp_load = 1'b1;
                    w_resp_to   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // rr_ptr starts at the last requester so that requester 0 wins first.
    always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rr_ptr  <= PTR_W'(NUM_REQ - 1);
            r_owner   <= '0;
            r_gnt     <= '0;
            r_data_in <= NOP_CMD;
        end else begin
            r_gnt <= '0;
            if (w_grant) begin
                r_rr_ptr     <= w_win;
                r_owner      <= w_win;
                r_gnt[w_win] <= 1'b1;
                r_data_in    <= w_cmd;
            end else if (w_resp_load) begin
                r_data_in <= NOP_CMD;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rsp_valid   <= '0;
            r_rsp_ok      <= 1'b0;
            r_rsp_ko      <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= '0;
            r_rsp_ok      <= w_resp_ok;
            r_rsp_ko      <= w_resp_ko;
            r_rsp_timeout <= w_resp_to;
            if (w_resp_load) begin
                r_rsp_valid[r_owner] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_timeout_cnt <= '0;
        end else if (r_state == S_RESP && r_rsp_timeout && r_timeout_cnt != 16'hFFFF) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    assign gnt          = r_gnt;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_ok       = r_rsp_ok;
    assign rsp_ko       = r_rsp_ko;
    assign rsp_timeout  = r_rsp_timeout;
    assign uram_data_in = r_data_in;
    assign sched_busy   = (r_state != S_IDLE);
    assign timeout_cnt  = r_timeout_cnt;

endmodule
